// File: rtl/ann_pkg.sv
// Shared types and default sizing for the MNIST output stage.
// Used by ann_argmax_classifier and the neuron-array top.
package ann_pkg;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int SCORE_W_DEF     = 16;
    localparam int IDX_W_DEF       = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W_DEF-1:0]   cls;
        logic [SCORE_W_DEF-1:0] score;
        logic                   err;
    } result_t;

endpackage

// File: rtl/ann_max_tracker.sv
// Combinational compare for the running {max, runner-up} pair.
// take_max wins over take_run; ties never displace the lower index.
module ann_max_tracker #(
    parameter int SCORE_W = 16
) (
    input  logic               is_first,
    input  logic               is_second,
    input  logic [SCORE_W-1:0] score,
    input  logic [SCORE_W-1:0] max_score,
    input  logic [SCORE_W-1:0] run_score,
    output logic               take_max,
    output logic               take_run
);

    assign take_max = is_first || (score > max_score);
    assign take_run = !take_max && (is_second || (score > run_score));

endmodule

// File: rtl/ann_argmax_classifier.sv
// Serial argmax over one frame of NUM_CLASSES activations, result held until accepted.
// Optional runner-up class and margin outputs when ARGMAX_RUNNERUP_EN is defined.
//   state | meaning
//   ACCUM | accepting score beats, tracking running max
//   HOLD  | result presented on out_*, waiting for out_ready
module ann_argmax_classifier
    import ann_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] in_score,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_class,
    output logic [SCORE_W-1:0] out_score,
    output logic               out_err
`ifdef ARGMAX_RUNNERUP_EN
    ,
    output logic [IDX_W-1:0]   out_second_class,
    output logic [SCORE_W-1:0] out_margin
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [SCORE_W-1:0] max_score, max_score_nxt;
    logic [IDX_W-1:0]   max_class, max_class_nxt;
    logic               accept, at_limit, frame_end;
    logic               take_max, take_run;
    logic [SCORE_W-1:0] run_score;
    logic               is_second;

    // in_ready is derived from state directly to keep accept free of the FSM comb block
    assign accept    = in_valid && (state == ACCUM);
    assign at_limit  = (cnt == LAST_IDX);
    assign frame_end = accept && (in_last || at_limit);

    ann_max_tracker #(.SCORE_W(SCORE_W)) u_tracker (
        .is_first  (cnt == '0),
        .is_second (is_second),
        .score     (in_score),
        .max_score (max_score),
        .run_score (run_score),
        .take_max  (take_max),
        .take_run  (take_run)
    );

    assign max_score_nxt = take_max ? in_score : max_score;
    assign max_class_nxt = take_max ? cnt : max_class;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (frame_end) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            max_score <= '0;
            max_class <= '0;
            out_class <= '0;
            out_score <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            max_score <= max_score_nxt;
            max_class <= max_class_nxt;
            if (frame_end) begin
                cnt       <= '0;
                out_class <= max_class_nxt;
                out_score <= max_score_nxt;
                out_err   <= in_last ^ at_limit;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef ARGMAX_RUNNERUP_EN
    logic [IDX_W-1:0]   run_class, run_class_nxt;
    logic [SCORE_W-1:0] run_score_nxt;

    assign is_second = (cnt == IDX_W'(1));

    // First beat seeds the runner-up with itself so a 1-beat frame reports margin 0
    always_comb begin
        run_score_nxt = run_score;
        run_class_nxt = run_class;
        if (cnt == '0) begin
            run_score_nxt = in_score;
            run_class_nxt = '0;
        end else if (take_max) begin
            run_score_nxt = max_score;
            run_class_nxt = max_class;
        end else if (take_run) begin
            run_score_nxt = in_score;
            run_class_nxt = cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_score        <= '0;
            run_class        <= '0;
            out_second_class <= '0;
            out_margin       <= '0;
        end else if (accept) begin
            run_score <= run_score_nxt;
            run_class <= run_class_nxt;
            if (frame_end) begin
                out_second_class <= run_class_nxt;
                out_margin       <= max_score_nxt - run_score_nxt;
            end
        end
    end
`else
    logic take_run_unused;

    assign run_score       = '0;
    assign is_second       = 1'b0;
    assign take_run_unused = take_run;
`endif

endmodule

// File: tb/tb_ann_argmax_classifier.sv
// Randomized + directed bench for ann_argmax_classifier against a top-2 reference model.
// Runner-up outputs are checked when ARGMAX_RUNNERUP_EN is defined.
module tb_ann_argmax_classifier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_score;
    logic        out_valid, out_ready, out_err;
    logic [3:0]  out_class;
    logic [15:0] out_score;
`ifdef ARGMAX_RUNNERUP_EN
    logic [3:0]  out_second_class;
    logic [15:0] out_margin;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] fs [16];

    ann_argmax_classifier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_score  (in_score),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .out_err   (out_err)
`ifdef ARGMAX_RUNNERUP_EN
        ,
        .out_second_class (out_second_class),
        .out_margin       (out_margin)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Top-2 by value; lowest index wins ties; runner-up excludes the winner.
    task automatic model(input int n, output logic [3:0] c, output logic [15:0] s,
                         output logic [3:0] c2, output logic [15:0] m);
        int mx = 0, mx2 = 0, ci = -1, ci2 = -1;
        for (int i = 0; i < n; i++) if (int'(fs[i]) > mx) mx = int'(fs[i]);
        for (int i = 0; i < n; i++) if (ci < 0 && int'(fs[i]) == mx) ci = i;
        for (int i = 0; i < n; i++) if (i != ci && int'(fs[i]) > mx2) mx2 = int'(fs[i]);
        for (int i = 0; i < n; i++) if (i != ci && ci2 < 0 && int'(fs[i]) == mx2) ci2 = i;
        c = 4'(ci);
        s = 16'(mx);
        if (n == 1) begin
            c2 = 4'd0;
            m  = 16'd0;
        end else begin
            c2 = 4'(ci2);
            m  = 16'(mx - mx2);
        end
    endtask

    task automatic send_beat(input logic [15:0] s, input logic l);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_score = s;
        in_last  = l;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("beat_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [3:0] c, input logic [15:0] s,
                                 input logic e, input logic [3:0] c2, input logic [15:0] m,
                                 input int stall);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_class"}, {28'd0, out_class}, {28'd0, c});
        check({tag, "_score"}, {16'd0, out_score}, {16'd0, s});
        check({tag, "_err"},   {31'd0, out_err},   {31'd0, e});
`ifdef ARGMAX_RUNNERUP_EN
        check({tag, "_second"}, {28'd0, out_second_class}, {28'd0, c2});
        check({tag, "_margin"}, {16'd0, out_margin}, {16'd0, m});
`else
        if (c2 > 4'd15 || m > 16'hFFFF) $display("unreachable");
`endif
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            in_score = 16'hFFFF;
            @(negedge clk);
            check({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_stall_class"}, {28'd0, out_class}, {28'd0, c});
            check({tag, "_stall_score"}, {16'd0, out_score}, {16'd0, s});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop"},  {31'd0, out_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready},  32'd1);
    endtask

    task automatic run_frame(input string tag, input int n, input logic last, input int stall);
        logic [3:0]  c, c2;
        logic [15:0] s, m;
        for (int i = 0; i < n; i++) send_beat(fs[i], (i == n - 1) ? last : 1'b0);
        model(n, c, s, c2, m);
        expect_result(tag, c, s, last ^ (n == 10), c2, m, stall);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_score = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_class", {28'd0, out_class}, 32'd0);
        check("rst_out_score", {16'd0, out_score}, 32'd0);
        check("rst_out_err",   {31'd0, out_err},   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) fs[i] = 16'((i + 1) * 16'h1000);
        run_frame("clean", 10, 1'b1, 0);

        for (int i = 0; i < 10; i++) fs[i] = 16'h0100;
        fs[2] = 16'hFFFF; fs[7] = 16'hFFFF;
        run_frame("tie", 10, 1'b1, 0);

        for (int i = 0; i < 10; i++) fs[i] = 16'($urandom_range(0, 65535));
        run_frame("backpressure", 10, 1'b1, 5);

        for (int i = 0; i < 10; i++) fs[i] = 16'h0200;
        fs[3] = 16'h8000;
        run_frame("short", 5, 1'b1, 0);

        for (int i = 0; i < 6; i++) send_beat(16'hF000 - 16'(i), 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_class", {28'd0, out_class}, 32'd0);
        check("arst_out_score", {16'd0, out_score}, 32'd0);
        check("arst_out_err",   {31'd0, out_err},   32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) fs[i] = 16'h0300 + 16'(i);
        fs[1] = 16'h0400;
        run_frame("after_rst", 10, 1'b1, 0);

        for (int i = 0; i < 10; i++) fs[i] = 16'(16'h2000 - 16'(i * 16'h100));
        run_frame("long", 10, 1'b0, 0);
        fs[0] = 16'h7777;
        run_frame("long_tail", 1, 1'b1, 0);

        for (int i = 0; i < 10; i++) fs[i] = 16'h1000;
        fs[4] = 16'hC000; fs[8] = 16'h9000;
        run_frame("runnerup", 10, 1'b1, 0);

        for (int f = 0; f < 30; f++) begin
            int n = int'($urandom_range(1, 10));
            logic last = (n < 10) ? 1'b1 : 1'($urandom_range(0, 1));
            bit narrow = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < n; i++)
                fs[i] = narrow ? 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 65535));
            run_frame("rand", n, last, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
